// File: rtl/xs3_to_bin_seq_if.sv
// ---------------------------------------------------------------------------
// xs3_to_bin_seq_if
//
// Handshake bundle for the sequential excess-3 to binary converter.
//
// Parameters:
//   DIGITS : number of excess-3 digits per word
//   OUT_W  : binary result width
//   PW     : error-position width (derived from DIGITS)
//
// Signals:
//   in_valid, in_digits : producer -> converter word request
//   in_ready            : converter -> producer, word can be taken
//   out_valid, out_bin, out_error, out_err_pos : converter -> consumer result
//   out_ready           : consumer -> converter, result taken
//
// Modports: master (producer/consumer side), slave (converter side).
// ---------------------------------------------------------------------------
interface xs3_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14,
  parameter int PW     = $clog2(DIGITS)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_digits;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_bin;
  logic                  out_error;
  logic [PW-1:0]         out_err_pos;

  modport master (
    output in_valid, in_digits, out_ready,
    input  in_ready, out_valid, out_bin, out_error, out_err_pos
  );

  modport slave (
    input  in_valid, in_digits, out_ready,
    output in_ready, out_valid, out_bin, out_error, out_err_pos
  );
endinterface

// File: rtl/xs3_to_bin_seq.sv
// ---------------------------------------------------------------------------
// xs3_to_bin_seq
//
// Multi-digit sequential excess-3 to binary converter. A packed word of
// DIGITS excess-3 digits (MS digit in the top nibble) is accepted over a
// valid/ready handshake and converted one digit per clock with
// acc <- acc*10 + (d-3). The result is held with an error flag and the
// index of the first digit outside 3..12 until the consumer takes it.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : xs3_to_bin_seq_if.slave (in_valid/in_ready/in_digits,
//         out_valid/out_ready/out_bin/out_error/out_err_pos)
//
// Configuration macro:
//   XS3_ERR_ABORT_EN : when defined, the first invalid digit ends the
//                      conversion immediately with out_bin forced to 0.
//                      When undefined, all DIGITS cycles always run and
//                      invalid digits contribute 0.
// ---------------------------------------------------------------------------
module xs3_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  xs3_to_bin_seq_if.slave   bus
);

  localparam int PW = $clog2(DIGITS);
  localparam logic [PW-1:0] LAST = PW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] sreg;
  logic [OUT_W-1:0]    acc;
  logic [PW-1:0]       cnt;
  logic                err;
  logic [PW-1:0]       err_pos;

  logic [3:0]          nib;
  logic                dig_ok;

  // acc*10 built from two shifts; wraps at OUT_W bits.
  function automatic logic [OUT_W-1:0] times10(input logic [OUT_W-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

  // Decoded digit value of a legal excess-3 nibble.
  function automatic logic [OUT_W-1:0] xs3_val(input logic [3:0] d);
    logic [3:0] v;
    v = d - 4'd3;
    return OUT_W'(v);
  endfunction

  assign nib    = sreg[4*DIGITS-1 -: 4];
  assign dig_ok = (nib >= 4'd3) && (nib <= 4'd12);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = CONV;
      CONV: begin
`ifdef XS3_ERR_ABORT_EN
        if (!dig_ok || cnt == LAST) state_nxt = DONE;
`else
        if (cnt == LAST) state_nxt = DONE;
`endif
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is also forced high during reset so the
  // producer sees the block as free the moment reset is released.
  always_comb begin
    bus.in_ready  = (state == IDLE) || rst;
    bus.out_valid = (state == DONE);
  end

  // Datapath: capture in IDLE, one digit per edge in CONV, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      err_pos <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg    <= bus.in_digits;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            err_pos <= '0;
          end
        end
        CONV: begin
          sreg <= {sreg[4*DIGITS-5:0], 4'h0};
          cnt  <= cnt + PW'(1);
          if (dig_ok) begin
            acc <= times10(acc) + xs3_val(nib);
          end else begin
`ifdef XS3_ERR_ABORT_EN
            acc <= '0;
`else
            acc <= times10(acc);
`endif
            // Only the first offending digit records its position.
            if (!err) begin
              err     <= 1'b1;
              err_pos <= cnt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_bin     = acc;
  assign bus.out_error   = err;
  assign bus.out_err_pos = err_pos;

endmodule

// File: tb/tb_xs3_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_xs3_to_bin_seq
//
// Directed self-checking bench for xs3_to_bin_seq (DIGITS=4, OUT_W=14).
// Expectations follow XS3_ERR_ABORT_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_xs3_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int OUT_W  = 14;
  localparam int PW     = $clog2(DIGITS);

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  xs3_to_bin_seq_if #(.DIGITS(DIGITS), .OUT_W(OUT_W), .PW(PW)) bus ();

  xs3_to_bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, wait for the result, check it and its latency, then
  // consume it (out_ready must already be high) and check in_ready returns.
  task automatic convert(input string tag, input logic [15:0] digits,
                         input int exp_bin, input int exp_err,
                         input int exp_pos, input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 20) begin tick(); w++; end
    chk({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_digits = digits;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_digits = 16'h0000;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_bin"},     32'(bus.out_bin), 32'(exp_bin));
    chk({tag, "_err"},     32'(bus.out_error), 32'(exp_err));
    chk({tag, "_pos"},     32'(bus.out_err_pos), 32'(exp_pos));
    chk({tag, "_busy"},    32'(bus.in_ready), 32'd0);
    tick();
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_vld_drop"},   32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int w;
    logic [OUT_W-1:0] held_bin;
    logic             held_err;
    logic [PW-1:0]    held_pos;

    bus.in_valid  = 1'b0;
    bus.in_digits = 16'h0000;
    bus.out_ready = 1'b1;

    // Reset, with a handshake attempt that must be ignored.
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h4567;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bin",   32'(bus.out_bin), 32'd0);
    chk("rst_out_err",   32'(bus.out_error), 32'd0);
    chk("rst_out_pos",   32'(bus.out_err_pos), 32'd0);
    chk("rst_idle",      32'(bus.in_ready), 32'd1);

    convert("w1234", 16'h4567, 1234, 0, 0, 4);
    convert("w0000", 16'h3333, 0,    0, 0, 4);
    convert("w9999", 16'hCCCC, 9999, 0, 0, 4);
`ifdef XS3_ERR_ABORT_EN
    convert("w4F67", 16'h4F67, 0, 1, 1, 2);
    convert("w0F1C", 16'h0F1C, 0, 1, 0, 1);
`else
    convert("w4F67", 16'h4F67, 1034, 1, 1, 4);
    convert("w0F1C", 16'h0F1C, 9,    1, 0, 4);
`endif

    // Backpressure: 16'h5555 -> 2222 held while in_valid/in_digits toggle.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h5555;
    tick();
    bus.in_valid  = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin tick(); w++; end
    chk("bp_latency", 32'(w), 32'd4);
    held_bin = bus.out_bin;
    held_err = bus.out_error;
    held_pos = bus.out_err_pos;
    chk("bp_bin", 32'(held_bin), 32'd2222);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = ~bus.in_valid;
      bus.in_digits = 16'h3334 + 16'(i * 16'h1111);
      tick();
      chk("bp_hold_bin",   32'(bus.out_bin), 32'(held_bin));
      chk("bp_hold_err",   32'(bus.out_error), 32'(held_err));
      chk("bp_hold_pos",   32'(bus.out_err_pos), 32'(held_pos));
      chk("bp_hold_vld",   32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",   32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_consumed_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_consumed_vld",   32'(bus.out_valid), 32'd0);
    tick();
    chk("bp_no_extra_word", 32'(bus.in_ready), 32'd1);

    // Reset on the second CONV edge of 16'h4567.
    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h4567;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_during", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_bin", 32'(bus.out_bin), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    convert("w0001", 16'h3334, 1, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
